grf_multiport: RTL and testbench

Parametrised general-purpose register file for the pipelined MIPS core, the successor to the two-read/one-write GRF. It provides N_RD combinational read ports, two prioritised write ports (A: younger producer, B: older producer), same-cycle write-to-read bypass, and a per-register pending scoreboard that hazard logic uses to generate stalls. It sits in the decode stage and is written from the writeback paths.

---
 rtl/grf_pkg.sv | 26 ++
 rtl/grf_scoreboard.sv | 83 ++++++++
 rtl/grf_multiport.sv | 93 +++++++++
 tb/tb_grf_multiport.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the multiport general-purpose register file.
// Packed port buses are unpacked through get_field so every consumer slices them the same way.
package grf_pkg;

  localparam int GRF_DATA_W  = 32;
  localparam int GRF_ADDR_W  = 5;
  localparam int FIELD_MAX_W = 64;
  localparam int BUS_MAX_W   = 4 * FIELD_MAX_W;

  localparam logic [GRF_ADDR_W-1:0] ZERO_REG = '0;

  // Returns field k of width w from a packed bus, zero-extended to FIELD_MAX_W.
  function automatic logic [FIELD_MAX_W-1:0] get_field(
    input logic [BUS_MAX_W-1:0] bus,
    input int                   k,
    input int                   w
  );
    logic [FIELD_MAX_W-1:0] f;
    f = '0;
    for (int i = 0; i < FIELD_MAX_W; i++) begin
      if (i < w) f[i] = bus[k*w + i];
    end
    return f;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending bits with issue/write/flush priority, a running popcount,
// and the busy flags seen by each read port.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int N_RD   = 2,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wa_en,
  input  logic [ADDR_W-1:0]      wa_addr,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   flush,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_busy,
  output logic [CNT_W-1:0]       pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0]  r_pend;
  logic [CNT_W-1:0]  r_cnt;
  logic [DEPTH-1:0]  w_set;
  logic [DEPTH-1:0]  w_clr;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_wa_ok;
  logic              w_wb_ok;
  logic              w_iss_ok;
  logic              w_inc;
  logic              w_dec_a;
  logic              w_dec_b;
  logic [ADDR_W-1:0] w_raddr [N_RD];

  assign w_wa_ok  = wa_en && (wa_addr != ZERO_A);
  assign w_wb_ok  = wb_en && (wb_addr != ZERO_A);
  assign w_iss_ok = iss_en && !flush && (iss_addr != ZERO_A);

  assign w_set = w_iss_ok ? (DEPTH'(1) << iss_addr) : '0;
  assign w_clr = (w_wa_ok ? (DEPTH'(1) << wa_addr) : '0)
               | (w_wb_ok ? (DEPTH'(1) << wb_addr) : '0);

  // Set is applied after clear so a new producer keeps ownership of its register.
  assign w_pend_nxt = flush ? '0 : ((r_pend & ~w_clr) | w_set);

  // Count only bits that actually flip; B is not double-counted when A hits the same register.
  assign w_inc   = w_iss_ok && !r_pend[iss_addr];
  assign w_dec_a = w_wa_ok && r_pend[wa_addr] && !w_set[wa_addr];
  assign w_dec_b = w_wb_ok && r_pend[wb_addr] && !w_set[wb_addr]
                && !(w_wa_ok && (wa_addr == wb_addr));

  assign w_cnt_nxt = flush ? '0
                   : (r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec_a) - CNT_W'(w_dec_b));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < N_RD; k++) begin
      w_raddr[k] = ADDR_W'(get_field(BUS_MAX_W'(rd_addr), k, ADDR_W));
      rd_busy[k] = r_pend[w_raddr[k]]
                && !(wa_en && (wa_addr == w_raddr[k]))
                && !(wb_en && (wb_addr == w_raddr[k]));
    end
  end

  assign pend_cnt = r_cnt;

endmodule

// File: rtl/grf_multiport.sv
// Register file with N_RD bypassed read ports, two prioritised write ports (A over B)
// and a pending scoreboard used by decode-stage hazard logic.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int N_RD   = 2,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   wa_en,
  input  logic [ADDR_W-1:0]      wa_addr,
  input  logic [DATA_W-1:0]      wa_data,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   flush,
  output logic [CNT_W-1:0]       pend_cnt,
  output logic                   wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              r_conflict;
  logic              w_wa_ok;
  logic              w_wb_ok;
  logic [ADDR_W-1:0] w_raddr [N_RD];
  logic [DATA_W-1:0] w_rdata [N_RD];

  assign w_wa_ok = wa_en && (wa_addr != ZERO_A);
  assign w_wb_ok = wb_en && (wb_addr != ZERO_A);

  // A is written last so it overrides B when both target the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_wb_ok) r_regs[wb_addr] <= wb_data;
      if (w_wa_ok) r_regs[wa_addr] <= wa_data;
      r_conflict <= w_wa_ok && w_wb_ok && (wa_addr == wb_addr);
    end
  end

  always_comb begin
    for (int k = 0; k < N_RD; k++) begin
      w_raddr[k] = ADDR_W'(get_field(BUS_MAX_W'(rd_addr), k, ADDR_W));
      if (w_raddr[k] == ZERO_A)
        w_rdata[k] = '0;
      else if (wa_en && (wa_addr == w_raddr[k]))
        w_rdata[k] = wa_data;
      else if (wb_en && (wb_addr == w_raddr[k]))
        w_rdata[k] = wb_data;
      else
        w_rdata[k] = r_regs[w_raddr[k]];
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd_pack
    assign rd_data[k*DATA_W +: DATA_W] = w_rdata[k];
  end

  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .pend_cnt (pend_cnt)
  );

  assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_grf_multiport.sv
// Bench for grf_multiport: directed scenarios plus a randomised phase against a
// behavioural model, with expectations queued and compared at the sample point.
module tb_grf_multiport;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_RD   = 2;
  localparam int CNT_W  = 6;
  localparam int DEPTH  = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_busy;
  logic                   wa_en, wb_en, iss_en, flush;
  logic [ADDR_W-1:0]      wa_addr, wb_addr, iss_addr;
  logic [DATA_W-1:0]      wa_data, wb_data;
  logic [CNT_W-1:0]       pend_cnt;
  logic                   wr_conflict;

  grf_multiport #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .N_RD (N_RD), .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wa_en       (wa_en),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .flush       (flush),
    .pend_cnt    (pend_cnt),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  // kind: 0/1 rd_data port, 2/3 rd_busy port, 4 pend_cnt, 5 wr_conflict
  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  logic [DEPTH-1:0]  m_pend;
  logic              m_conf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0:       return rd_data[31:0];
      1:       return rd_data[63:32];
      2:       return {31'b0, rd_busy[0]};
      3:       return {31'b0, rd_busy[1]};
      4:       return {26'b0, pend_cnt};
      default: return {31'b0, wr_conflict};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, observe(e.kind), e.exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (wa_en && wa_addr == a) return wa_data;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = (a != 0) && m_pend[a] && !(wa_en && wa_addr == a) && !(wb_en && wb_addr == a);
    return {31'b0, b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_pend = '0;
    m_conf = 1'b0;
  endtask

  task automatic model_edge();
    m_conf = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
    if (flush) begin
      m_pend = '0;
    end else begin
      if (wa_en && wa_addr != 0) m_pend[wa_addr] = 1'b0;
      if (wb_en && wb_addr != 0) m_pend[wb_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  task automatic clear_inputs();
    wa_en = 0; wa_addr = '0; wa_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Queue model predictions for this cycle, compare at negedge, then advance the model with the edge.
  task automatic step();
    @(negedge clk);
    push("rd0", 0, m_read(rd_addr[4:0]));
    push("rd1", 1, m_read(rd_addr[9:5]));
    push("busy0", 2, m_busy(rd_addr[4:0]));
    push("busy1", 3, m_busy(rd_addr[9:5]));
    push("pend_cnt", 4, 32'($countones(m_pend)));
    push("wr_conflict", 5, {31'b0, m_conf});
    drain();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(ADDR_W'(a), ADDR_W'(a));
      #1;
      push(tag, 0, 32'h0);
      push(tag, 1, 32'h0);
      push(tag, 2, 32'h0);
      drain();
    end
    push(tag, 4, 32'h0);
    push(tag, 5, 32'h0);
    drain();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    rd_addr = '0;
    model_reset();
    #1 reset = 1'b1;
    #10;
    check_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // Bypass on port A, then stored value.
    wa_en = 1; wa_addr = 5; wa_data = 32'h1234_5678; set_rd(5, 0);
    push("bypass_a5", 0, 32'h1234_5678);
    step();
    clear_inputs(); set_rd(5, 5);
    push("stored_a5", 0, 32'h1234_5678);
    step();

    // Same-address A/B write: A wins, conflict pulses once.
    wa_en = 1; wa_addr = 9; wa_data = 32'hAAAA_AAAA;
    wb_en = 1; wb_addr = 9; wb_data = 32'hBBBB_BBBB; set_rd(9, 9);
    push("conflict_bypass", 1, 32'hAAAA_AAAA);
    step();
    clear_inputs(); set_rd(9, 0);
    push("conflict_store", 0, 32'hAAAA_AAAA);
    push("conflict_pulse", 5, 32'h1);
    step();
    push("conflict_drop", 5, 32'h0);
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF;
    wb_en = 1; wb_addr = 0; wb_data = 32'hEEEE_EEEE; set_rd(0, 0);
    push("zero_bypass", 0, 32'h0);
    step();
    clear_inputs();
    push("zero_stored", 1, 32'h0);
    push("zero_no_conflict", 5, 32'h0);
    step();

    // Scoreboard set/clear.
    iss_en = 1; iss_addr = 3; step();
    iss_addr = 4; step();
    iss_addr = 7; step();
    clear_inputs(); set_rd(3, 4);
    push("busy3", 2, 32'h1); push("busy4", 3, 32'h1); push("pend3", 4, 32'd3);
    step();
    wb_en = 1; wb_addr = 4; wb_data = 32'h0000_0044; set_rd(4, 7);
    push("busy4_write", 2, 32'h0); push("busy7", 3, 32'h1);
    step();
    clear_inputs(); set_rd(4, 7);
    push("pend2", 4, 32'd2); push("data4", 0, 32'h0000_0044);
    step();
    iss_en = 1; iss_addr = 7; wa_en = 1; wa_addr = 7; wa_data = 32'h0000_0077;
    step();
    clear_inputs(); set_rd(7, 0);
    push("busy7_keep", 2, 32'h1); push("pend2_keep", 4, 32'd2); push("data7", 0, 32'h0000_0077);
    step();

    // Flush drops a same-cycle issue.
    flush = 1; iss_en = 1; iss_addr = 10;
    step();
    clear_inputs(); set_rd(10, 3);
    push("flush_pend", 4, 32'h0); push("flush_busy10", 2, 32'h0); push("flush_busy3", 3, 32'h0);
    step();

    // Randomised traffic, addresses biased low to force collisions.
    for (int n = 0; n < 400; n++) begin
      wa_en    = 1'($urandom_range(0, 1));
      wa_addr  = ADDR_W'($urandom_range(0, (n % 4 == 0) ? 31 : 7));
      wa_data  = $urandom;
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = ADDR_W'($urandom_range(0, 7));
      wb_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 2) != 0);
      iss_addr = ADDR_W'($urandom_range(0, (n % 3 == 0) ? 31 : 7));
      flush    = ($urandom_range(0, 29) == 0);
      set_rd(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 31)));
      step();
    end

    // Asynchronous reset between edges with state present.
    clear_inputs(); flush = 1; step();
    clear_inputs(); iss_en = 1; iss_addr = 1; wa_en = 1; wa_addr = 20; wa_data = 32'hCAFE_0020; step();
    clear_inputs(); iss_en = 1; iss_addr = 2; wb_en = 1; wb_addr = 21; wb_data = 32'hCAFE_0021; step();
    clear_inputs(); iss_en = 1; iss_addr = 3; step();
    clear_inputs(); set_rd(1, 20);
    #2;
    push("pre_reset_pend", 4, 32'd3); push("pre_reset_busy1", 2, 32'h1);
    push("pre_reset_data20", 1, 32'hCAFE_0020);
    drain();
    reset = 1'b1;
    #1;
    push("async_pend", 4, 32'h0); push("async_busy1", 2, 32'h0); push("async_data20", 1, 32'h0);
    drain();
    wa_en = 1; wa_addr = 12; wa_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("post_reset");
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
